// File: rtl/demux2_pkg.sv
// Shared types for the buffered 2-way demux and its one-entry pipeline buffers.
package demux2_pkg;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/demux2_buffered_rtl_if.sv
// Valid/ready bundle for the buffered demux: one input stream, two output streams, two counters.
interface demux2_buffered_rtl_if #(
    parameter int unsigned p_nbits     = 32,
    parameter int unsigned p_cnt_nbits = 8
);
    logic                   in_val;
    logic                   in_rdy;
    logic                   in_sel;
    logic [p_nbits-1:0]     in_msg;
    logic                   out0_val;
    logic                   out0_rdy;
    logic [p_nbits-1:0]     out0_msg;
    logic                   out1_val;
    logic                   out1_rdy;
    logic [p_nbits-1:0]     out1_msg;
    logic [p_cnt_nbits-1:0] cnt0;
    logic [p_cnt_nbits-1:0] cnt1;

    // Producer/consumer side
    modport master (
        output in_val, in_sel, in_msg, out0_rdy, out1_rdy,
        input  in_rdy, out0_val, out0_msg, out1_val, out1_msg, cnt0, cnt1
    );

    // Demux side
    modport slave (
        input  in_val, in_sel, in_msg, out0_rdy, out1_rdy,
        output in_rdy, out0_val, out0_msg, out1_val, out1_msg, cnt0, cnt1
    );
endinterface

// File: rtl/demux2_buffered_rtl_pipe_buf1.sv
// One-entry pipelined buffer: accepts when empty or when the consumer drains it the same cycle.
module pipe_buf1_rtl
    import demux2_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enq,
    input  logic [p_nbits-1:0] i_data,
    input  logic               i_rdy,
    output logic               o_val,
    output logic [p_nbits-1:0] o_data,
    output logic               o_can_acc
);

    buf_state_t         r_state;
    logic [p_nbits-1:0] r_data;
    logic               w_deq;

    assign w_deq     = (r_state == BUF_FULL) && i_rdy;
    assign o_val     = (r_state == BUF_FULL);
    assign o_data    = r_data;
    assign o_can_acc = (r_state == BUF_EMPTY) || i_rdy;

    // Enqueue while FULL is only possible when the consumer is ready, so it replaces the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (i_enq) begin
                        r_state <= BUF_FULL;
                        r_data  <= i_data;
                    end
                end
                BUF_FULL: begin
                    if (i_enq) begin
                        r_data <= i_data;
                    end else if (w_deq) begin
                        r_state <= BUF_EMPTY;
                    end
                end
                default: r_state <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/demux2_buffered_rtl.sv
// Buffered 1:2 demux: steers each message by in_sel into a per-output one-entry buffer
// and counts deliveries on each output.
module demux2_buffered_rtl
    import demux2_pkg::*;
#(
    parameter int unsigned p_nbits     = 32,
    parameter int unsigned p_cnt_nbits = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    demux2_buffered_rtl_if.slave  bus
);

    logic                   w_can_acc0;
    logic                   w_can_acc1;
    logic                   w_in_rdy;
    logic                   w_enq0;
    logic                   w_enq1;
    logic                   w_out0_val;
    logic                   w_out1_val;
    logic                   w_deq0;
    logic                   w_deq1;
    logic [p_cnt_nbits-1:0] r_cnt0;
    logic [p_cnt_nbits-1:0] r_cnt1;

    // Ready follows the selected buffer even when no message is offered.
    assign w_in_rdy = bus.in_sel ? w_can_acc1 : w_can_acc0;
    assign w_enq0   = bus.in_val && w_in_rdy && !bus.in_sel;
    assign w_enq1   = bus.in_val && w_in_rdy &&  bus.in_sel;
    assign w_deq0   = w_out0_val && bus.out0_rdy;
    assign w_deq1   = w_out1_val && bus.out1_rdy;

    assign bus.in_rdy   = w_in_rdy;
    assign bus.out0_val = w_out0_val;
    assign bus.out1_val = w_out1_val;
    assign bus.cnt0     = r_cnt0;
    assign bus.cnt1     = r_cnt1;

    pipe_buf1_rtl #(.p_nbits(p_nbits)) u_buf0 (
        .clk       (clk),
        .rst       (rst),
        .i_enq     (w_enq0),
        .i_data    (bus.in_msg),
        .i_rdy     (bus.out0_rdy),
        .o_val     (w_out0_val),
        .o_data    (bus.out0_msg),
        .o_can_acc (w_can_acc0)
    );

    pipe_buf1_rtl #(.p_nbits(p_nbits)) u_buf1 (
        .clk       (clk),
        .rst       (rst),
        .i_enq     (w_enq1),
        .i_data    (bus.in_msg),
        .i_rdy     (bus.out1_rdy),
        .o_val     (w_out1_val),
        .o_data    (bus.out1_msg),
        .o_can_acc (w_can_acc1)
    );

    // Delivery counters wrap naturally at 2^p_cnt_nbits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_deq0) r_cnt0 <= r_cnt0 + p_cnt_nbits'(1);
            if (w_deq1) r_cnt1 <= r_cnt1 + p_cnt_nbits'(1);
        end
    end

endmodule
